shift_sequencer: RTL and testbench

- Multi-cycle shift unit for the MIPS ALU path, executing SLL/SRL/SRA with a variable 5-bit shift amount.
- Each cycle it applies one fixed shift step: by-2 (same as the branch-offset stage) or by-1.
- The step repeats until the shift amount is consumed, replacing a full barrel shifter with a small area-cheap stage plus control.
- Start/Done handshake to the multicycle control unit; result held stable until the next accepted Start.

---
 rtl/shift_sequencer.sv | 124 ++++++++++++
 tb/tb_shift_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer
// Purpose  : Multi-cycle SLL/SRL/SRA unit. A small fixed-step shifter (by-2,
//            by-1) is applied once per cycle until the shift amount is used
//            up, with a Start/Done handshake to the multicycle control unit.
// Options  : SHIFT_SEQ_STEP4_EN adds a by-4 step taken with top priority.
// Revision : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               Clock,
  input  logic               ResetN,
  input  logic               Start,
  input  logic [1:0]         Op,
  input  logic [WIDTH-1:0]   Operand,
  input  logic [SHAMT_W-1:0] Shamt,
  output logic               Busy,
  output logic               Done,
  output logic [WIDTH-1:0]   Result
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_RSV = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   work, work_nxt;
  logic [SHAMT_W-1:0] remaining, remaining_nxt;
  logic [1:0]         op_q, op_nxt;
  logic               sign_q, sign_nxt;

  // Fill bit for right shifts: latched sign for SRA, zero for SRL.
  logic             fill;
  logic [WIDTH-1:0] left1, left2, right1, right2;
`ifdef SHIFT_SEQ_STEP4_EN
  logic [WIDTH-1:0] left4, right4;
`endif

  // Fixed-distance shift candidates from the working register.
  always_comb begin
    fill   = (op_q == OP_SRA) & sign_q;
    left1  = {work[WIDTH-2:0], 1'b0};
    left2  = {work[WIDTH-3:0], 2'b00};
    right1 = {fill, work[WIDTH-1:1]};
    right2 = {{2{fill}}, work[WIDTH-1:2]};
`ifdef SHIFT_SEQ_STEP4_EN
    left4  = {work[WIDTH-5:0], 4'b0000};
    right4 = {{4{fill}}, work[WIDTH-1:4]};
`endif
  end

  // Next-state, accept and per-step shift control.
  always_comb begin
    state_nxt     = state;
    work_nxt      = work;
    remaining_nxt = remaining;
    op_nxt        = op_q;
    sign_nxt      = sign_q;
    case (state)
      IDLE, DONE: begin
        if (Start) begin
          work_nxt      = Operand;
          op_nxt        = Op;
          remaining_nxt = Shamt;
          sign_nxt      = Operand[WIDTH-1];
          // Nothing to shift: report the operand unchanged right away.
          if ((Shamt == '0) || (Op == OP_RSV)) state_nxt = DONE;
          else                                  state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
`ifdef SHIFT_SEQ_STEP4_EN
        if (remaining >= SHAMT_W'(4)) begin
          work_nxt      = (op_q == OP_SLL) ? left4 : right4;
          remaining_nxt = remaining - SHAMT_W'(4);
        end else
`endif
        if (remaining >= SHAMT_W'(2)) begin
          work_nxt      = (op_q == OP_SLL) ? left2 : right2;
          remaining_nxt = remaining - SHAMT_W'(2);
        end else begin
          work_nxt      = (op_q == OP_SLL) ? left1 : right1;
          remaining_nxt = '0;
        end
        if (remaining_nxt == '0) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state     <= IDLE;
      work      <= '0;
      remaining <= '0;
      op_q      <= '0;
      sign_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      work      <= work_nxt;
      remaining <= remaining_nxt;
      op_q      <= op_nxt;
      sign_q    <= sign_nxt;
    end
  end

  assign Busy   = (state == SHIFT);
  assign Done   = (state == DONE);
  assign Result = work;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_sequencer
// Purpose  : Directed self-checking bench for shift_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

  logic        Clock;
  logic        ResetN;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] Operand;
  logic [4:0]  Shamt;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;

  int vecs;
  int errs;

  shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
    .Clock   (Clock),
    .ResetN  (ResetN),
    .Start   (Start),
    .Op      (Op),
    .Operand (Operand),
    .Shamt   (Shamt),
    .Busy    (Busy),
    .Done    (Done),
    .Result  (Result)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Expected accept-to-Done latency in cycles for a shifting op.
  function automatic int exp_lat(input int r);
`ifdef SHIFT_SEQ_STEP4_EN
    return r / 4 + (r % 4) / 2 + (r % 2) + 1;
`else
    return (r + 1) / 2 + 1;
`endif
  endfunction

  // Present a request (called at a negedge); return just after the accept edge
  // with the inputs scrambled so late changes would be visible if they leaked.
  task automatic issue(input logic [1:0] op, input logic [31:0] opnd, input logic [4:0] sh);
    Start   = 1'b1;
    Op      = op;
    Operand = opnd;
    Shamt   = sh;
    @(posedge Clock);
    #1;
    Start   = 1'b0;
    Op      = ~op;
    Operand = 32'hA5A5_5A5A;
    Shamt   = ~sh;
  endtask

  // Observe a window of cycles after an accept edge (first negedge is cycle 1).
  task automatic measure(input int win, output int first_done, output int busy_cnt,
                         output int done_cnt, output logic [31:0] res_done);
    first_done = 0;
    busy_cnt   = 0;
    done_cnt   = 0;
    res_done   = 32'hx;
    for (int k = 1; k <= win; k++) begin
      @(negedge Clock);
      if (Busy) busy_cnt++;
      if (Done) begin
        done_cnt++;
        if (first_done == 0) begin
          first_done = k;
          res_done   = Result;
        end
      end
    end
  endtask

  task automatic test_reset();
    ResetN = 1'b0; Start = 1'b0; Op = 2'b00; Operand = 32'h0; Shamt = 5'd0;
    repeat (3) @(negedge Clock);
    vecs++;
    if ({Busy, Done, Result} !== 34'h0) begin
      errs++;
      $display("FAIL reset_outputs: got busy=%b done=%b result=%h, need 0 0 00000000", Busy, Done, Result);
    end
    ResetN = 1'b1;
    @(negedge Clock);
    vecs++;
    if ({Busy, Done, Result} !== 34'h0) begin
      errs++;
      $display("FAIL idle_after_reset: got busy=%b done=%b result=%h, need 0 0 00000000", Busy, Done, Result);
    end
  endtask

  task automatic test_sll_max();
    int fd, bc, dc; logic [31:0] rd;
    issue(2'b00, 32'h0000_0001, 5'd31);
    measure(20, fd, bc, dc, rd);
    vecs++;
    if (rd !== 32'h8000_0000) begin errs++; $display("FAIL sll31_result: got %h, need 80000000", rd); end
    vecs++;
    if (fd !== exp_lat(31)) begin errs++; $display("FAIL sll31_latency: got %0d, need %0d", fd, exp_lat(31)); end
    vecs++;
    if (bc !== exp_lat(31) - 1) begin errs++; $display("FAIL sll31_busy: got %0d, need %0d", bc, exp_lat(31) - 1); end
    vecs++;
    if (dc !== 1) begin errs++; $display("FAIL sll31_done_count: got %0d, need 1", dc); end
    vecs++;
    if (Result !== 32'h8000_0000) begin errs++; $display("FAIL sll31_hold: got %h, need 80000000", Result); end
  endtask

  task automatic test_sign_fill();
    int fd, bc, dc; logic [31:0] rd;
    issue(2'b11, 32'h8000_0000, 5'd4);
    measure(6, fd, bc, dc, rd);
    vecs++;
    if (rd !== 32'hF800_0000) begin errs++; $display("FAIL sra4_result: got %h, need f8000000", rd); end
    vecs++;
    if (fd !== exp_lat(4)) begin errs++; $display("FAIL sra4_latency: got %0d, need %0d", fd, exp_lat(4)); end
    issue(2'b01, 32'h8000_0000, 5'd4);
    measure(6, fd, bc, dc, rd);
    vecs++;
    if (rd !== 32'h0800_0000) begin errs++; $display("FAIL srl4_result: got %h, need 08000000", rd); end
    issue(2'b11, 32'h4000_0000, 5'd3);
    measure(6, fd, bc, dc, rd);
    vecs++;
    if (rd !== 32'h0800_0000) begin errs++; $display("FAIL sra3_pos_result: got %h, need 08000000", rd); end
    vecs++;
    if (fd !== exp_lat(3)) begin errs++; $display("FAIL sra3_latency: got %0d, need %0d", fd, exp_lat(3)); end
    issue(2'b11, 32'hC000_0010, 5'd5);
    measure(6, fd, bc, dc, rd);
    vecs++;
    if (rd !== 32'hFE00_0000) begin errs++; $display("FAIL sra5_result: got %h, need fe000000", rd); end
  endtask

  task automatic test_zero_reserved();
    int fd, bc, dc; logic [31:0] rd;
    issue(2'b00, 32'hDEAD_BEEF, 5'd0);
    measure(4, fd, bc, dc, rd);
    vecs++;
    if ({fd, bc, rd} !== {32'd1, 32'd0, 32'hDEAD_BEEF}) begin
      errs++; $display("FAIL zero_shamt: got done_at=%0d busy=%0d result=%h, need 1 0 deadbeef", fd, bc, rd);
    end
    issue(2'b10, 32'hDEAD_BEEF, 5'd7);
    measure(4, fd, bc, dc, rd);
    vecs++;
    if ({fd, bc, rd} !== {32'd1, 32'd0, 32'hDEAD_BEEF}) begin
      errs++; $display("FAIL reserved_op: got done_at=%0d busy=%0d result=%h, need 1 0 deadbeef", fd, bc, rd);
    end
  endtask

  task automatic test_busy_ignore();
    int fd, dc; logic [31:0] rd;
    fd = 0; dc = 0; rd = 32'hx;
    issue(2'b00, 32'h0000_0001, 5'd8);
    for (int k = 1; k <= 10; k++) begin
      @(negedge Clock);
      if (Done) begin
        dc++;
        if (fd == 0) begin fd = k; rd = Result; end
      end
      if (k == 2) begin
        Start = 1'b1; Op = 2'b00; Operand = 32'hFFFF_FFFF; Shamt = 5'd1;
      end else begin
        Start = 1'b0;
      end
    end
    vecs++;
    if (rd !== 32'h0000_0100) begin errs++; $display("FAIL busy_ignore_result: got %h, need 00000100", rd); end
    vecs++;
    if (dc !== 1 || fd !== exp_lat(8)) begin
      errs++; $display("FAIL busy_ignore_done: got count=%0d at=%0d, need 1 at %0d", dc, fd, exp_lat(8));
    end
  endtask

  task automatic test_back_to_back();
    int fd, bc, dc; logic [31:0] rd;
    issue(2'b00, 32'h0000_0003, 5'd2);
    @(negedge Clock);
    @(negedge Clock);
    vecs++;
    if ({Done, Result} !== {1'b1, 32'h0000_000C}) begin
      errs++; $display("FAIL b2b_first: got done=%b result=%h, need 1 0000000c", Done, Result);
    end
    issue(2'b01, 32'h0000_00F0, 5'd4);
    measure(6, fd, bc, dc, rd);
    vecs++;
    if ({fd, dc, rd} !== {exp_lat(4), 32'd1, 32'h0000_000F}) begin
      errs++; $display("FAIL b2b_second: got at=%0d count=%0d result=%h, need %0d 1 0000000f", fd, dc, rd, exp_lat(4));
    end
  endtask

  task automatic test_reset_mid();
    int fd, bc, dc; logic [31:0] rd;
    issue(2'b00, 32'h0000_0001, 5'd20);
    repeat (3) @(negedge Clock);
    #2 ResetN = 1'b0;
    #1;
    vecs++;
    if ({Busy, Done, Result} !== 34'h0) begin
      errs++; $display("FAIL async_reset: got busy=%b done=%b result=%h, need 0 0 00000000", Busy, Done, Result);
    end
    @(negedge Clock);
    ResetN = 1'b1;
    measure(15, fd, bc, dc, rd);
    vecs++;
    if ({dc, bc} !== 64'd0) begin
      errs++; $display("FAIL reset_no_done: got done_count=%0d busy=%0d, need 0 0", dc, bc);
    end
    issue(2'b11, 32'h8000_0000, 5'd1);
    measure(4, fd, bc, dc, rd);
    vecs++;
    if ({fd, rd} !== {exp_lat(1), 32'hC000_0000}) begin
      errs++; $display("FAIL after_reset_op: got at=%0d result=%h, need %0d c0000000", fd, rd, exp_lat(1));
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_sll_max();
    test_sign_fill();
    test_zero_reserved();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  // Absolute time limit so a stuck run still reports.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, need completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
